// File: rtl/ncc_feeder.sv
// ncc_feeder: streams a 64-word descriptor to the NCC engine, then builds every 16x16 window of
// the search region in raster order. Define NCC_FEEDER_COL_REUSE_EN to reuse 15 columns between adjacent windows.
module ncc_feeder #(
   parameter int ADDR_W   = 16,
   parameter int WIN_COLS = 15,
   parameter int WIN_ROWS = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      desc_base,
   input  logic [ADDR_W-1:0]      region_base,
   output logic                   busy,
   output logic                   done,
   output logic                   desc_rd,
   output logic [ADDR_W-1:0]      desc_addr,
   input  logic [31:0]            desc_rdata,
   output logic                   pix_rd,
   output logic [ADDR_W-1:0]      pix_addr,
   input  logic [7:0]             pix_rdata,
   output logic                   desc_data_ready,
   output logic [31:0]            desc_data,
   output logic [15:0][15:0][7:0] window_data,
   output logic                   window_data_ready,
   input  logic                   done_with_window_data,
   output logic [8:0]             window_index
);

   localparam int REGION_W   = WIN_COLS + 15;
   localparam int NUM_WIN    = WIN_COLS * WIN_ROWS;
   localparam int DESC_WORDS = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DESC,
      S_FILL,
      S_PRESENT,
      S_WAIT_ACK
   } state_t;

   state_t                   state_q, state_d;
   logic [8:0]               cnt_q, cnt_d;
   logic [ADDR_W-1:0]        desc_base_q, desc_base_d;
   logic [ADDR_W-1:0]        region_base_q, region_base_d;
   logic [ADDR_W-1:0]        wx_q, wx_d;
   logic [ADDR_W-1:0]        wy_q, wy_d;
   logic [8:0]               idx_q, idx_d;
   logic                     desc_vld_q, desc_vld_d;
   logic                     done_q, done_d;
   logic [15:0][15:0][7:0]   win_q, win_d;

   logic                     col_reuse;
   logic [8:0]               fill_reads;
   logic                     fill_last;
   logic                     last_win;
   logic                     last_col;
   logic [7:0]               wr_cnt;
   logic [3:0]               rd_row, rd_col;
   logic [3:0]               wr_row, wr_col;
   logic [ADDR_W-1:0]        row_sum;
   logic [ADDR_W-1:0]        pix_addr_calc;

`ifdef NCC_FEEDER_COL_REUSE_EN
   // Horizontally adjacent windows share 15 columns; only the leftmost window of a row is read in full.
   assign col_reuse = (wx_q != '0);
`else
   assign col_reuse = 1'b0;
`endif

   assign fill_reads = col_reuse ? 9'd16 : 9'd256;
   assign fill_last  = (cnt_q == fill_reads);
   assign last_win   = (idx_q == 9'(NUM_WIN - 1));
   assign last_col   = (wx_q == ADDR_W'(WIN_COLS - 1));

   // Read pointer walks the window raster (or column 15 only); the write pointer trails it by one cycle.
   assign wr_cnt = cnt_q[7:0] - 8'd1;
   assign rd_row = col_reuse ? cnt_q[3:0]  : cnt_q[7:4];
   assign rd_col = col_reuse ? 4'hF        : cnt_q[3:0];
   assign wr_row = col_reuse ? wr_cnt[3:0] : wr_cnt[7:4];
   assign wr_col = col_reuse ? 4'hF        : wr_cnt[3:0];

   assign row_sum       = wy_q + ADDR_W'(rd_row);
   assign pix_addr_calc = region_base_q + row_sum * ADDR_W'(REGION_W) + wx_q + ADDR_W'(rd_col);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start) state_d = S_DESC;
         S_DESC:     if (cnt_q == 9'(DESC_WORDS - 1)) state_d = S_FILL;
         S_FILL:     if (fill_last) state_d = S_PRESENT;
         S_PRESENT:  state_d = S_WAIT_ACK;
         S_WAIT_ACK: if (done_with_window_data) state_d = last_win ? S_IDLE : S_FILL;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy              = (state_q != S_IDLE);
      desc_rd           = 1'b0;
      desc_addr         = '0;
      pix_rd            = 1'b0;
      pix_addr          = '0;
      window_data_ready = 1'b0;
      case (state_q)
         S_DESC: begin
            desc_rd   = 1'b1;
            desc_addr = desc_base_q + ADDR_W'(cnt_q);
         end
         S_FILL: begin
            if (cnt_q < fill_reads) begin
               pix_rd   = 1'b1;
               pix_addr = pix_addr_calc;
            end
         end
         S_PRESENT: window_data_ready = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      cnt_d         = cnt_q;
      desc_base_d   = desc_base_q;
      region_base_d = region_base_q;
      wx_d          = wx_q;
      wy_d          = wy_q;
      idx_d         = idx_q;
      win_d         = win_q;
      done_d        = 1'b0;
      desc_vld_d    = desc_rd;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               desc_base_d   = desc_base;
               region_base_d = region_base;
               wx_d          = '0;
               wy_d          = '0;
               idx_d         = '0;
               cnt_d         = '0;
            end
         end
         S_DESC: cnt_d = (cnt_q == 9'(DESC_WORDS - 1)) ? 9'd0 : cnt_q + 9'd1;
         S_FILL: begin
            cnt_d = fill_last ? 9'd0 : cnt_q + 9'd1;
            if (col_reuse && cnt_q == 9'd0) begin
               for (int r = 0; r < 16; r++) begin
                  for (int c = 0; c < 15; c++) begin
                     win_d[r][c] = win_q[r][c+1];
                  end
               end
            end
            if (cnt_q != 9'd0) begin
               win_d[wr_row][wr_col] = pix_rdata;
            end
         end
         S_WAIT_ACK: begin
            if (done_with_window_data) begin
               if (last_win) begin
                  done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 9'd1;
                  if (last_col) begin
                     wx_d = '0;
                     wy_d = wy_q + ADDR_W'(1);
                  end else begin
                     wx_d = wx_q + ADDR_W'(1);
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // NOTE: the window store is a reset flop array, not a RAM, because every byte must read 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         desc_base_q   <= '0;
         region_base_q <= '0;
         wx_q          <= '0;
         wy_q          <= '0;
         idx_q         <= '0;
         desc_vld_q    <= 1'b0;
         done_q        <= 1'b0;
         win_q         <= '0;
      end else begin
         cnt_q         <= cnt_d;
         desc_base_q   <= desc_base_d;
         region_base_q <= region_base_d;
         wx_q          <= wx_d;
         wy_q          <= wy_d;
         idx_q         <= idx_d;
         desc_vld_q    <= desc_vld_d;
         done_q        <= done_d;
         win_q         <= win_d;
      end
   end

   assign done            = done_q;
   assign desc_data_ready = desc_vld_q;
   assign desc_data       = desc_vld_q ? desc_rdata : 32'd0;
   assign window_data     = win_q;
   assign window_index    = idx_q;

endmodule
